// File: rtl/tdm_demux.sv
// TDM receiver: tracks slot position from a slot-0 sync strobe, buffers the
// partial frame and publishes each complete frame atomically with a pulse.
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              sync,
    output logic [N_CH*W-1:0] ch_out,
    output logic              frame_valid,
    output logic              locked,
    output logic              sync_err
);

    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       slot_q, slot_d;
    // Slots 0..N_CH-2 are buffered; the last slot goes straight to ch_out.
    logic [W-1:0]        shadow_q [N_CH-1];
    logic [W-1:0]        shadow_d [N_CH-1];
    logic [N_CH*W-1:0]   ch_out_q, ch_out_d;
    logic                fv_q, fv_d;
    logic                err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= UNLOCKED;
            slot_q   <= '0;
            ch_out_q <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            for (int k = 0; k < N_CH-1; k++) shadow_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            ch_out_q <= ch_out_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            for (int k = 0; k < N_CH-1; k++) shadow_q[k] <= shadow_d[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        ch_out_d = ch_out_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        for (int k = 0; k < N_CH-1; k++) shadow_d[k] = shadow_q[k];

        if (din_valid) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = SW'(1);
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot_q == '0) begin
                        if (sync) begin
                            shadow_d[0] = din;
                            slot_d      = SW'(1);
                        end else begin
                            err_d   = 1'b1;
                            state_d = UNLOCKED;
                            slot_d  = '0;
                        end
                    end else if (sync) begin
                        // Early sync: drop the partial frame, restart at slot 0.
                        err_d       = 1'b1;
                        shadow_d[0] = din;
                        slot_d      = SW'(1);
                    end else if (slot_q == SW'(N_CH-1)) begin
                        for (int k = 0; k < N_CH-1; k++)
                            ch_out_d[k*W +: W] = shadow_q[k];
                        ch_out_d[(N_CH-1)*W +: W] = din;
                        fv_d   = 1'b1;
                        slot_d = '0;
                    end else begin
                        for (int k = 0; k < N_CH-1; k++)
                            if (slot_q == SW'(k)) shadow_d[k] = din;
                        slot_d = slot_q + SW'(1);
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    slot_d  = '0;
                end
            endcase
        end
    end

    assign ch_out      = ch_out_q;
    assign frame_valid = fv_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = err_q;

endmodule
